// File: rtl/joy_db15_tx.sv
// joy_db15_tx: responder end of the DB15 serial joystick link.
//
// Emulates the adapter's 74HC165-style parallel-in/serial-out chain. While the
// host holds joy_load low, both player button vectors are captured (inverted,
// since the link is active-low). Each host joy_clk rising edge then shifts one
// bit out on joy_data: joystick1[0..PLAYER_BITS-1], then joystick2[0..].
// Once the frame is exhausted, 1s (released) are shifted in.
//
// Ports:
//   clk          system clock (40-50 MHz)
//   reset        synchronous, active-high
//   joy_clk      host shift clock, asynchronous, shifts on rising edge
//   joy_load     host load strobe, asynchronous, active-low, level-sensitive
//   joystick1/2  player buttons, active-high, bit0 = R, L, D, U, A-F, S, M/L
//   turbo_mask   (turbo build only) buttons subject to turbo auto-release
//   joy_data     serial data to host, active-low (pressed = 0)
//   frame_done   one-cycle pulse when the last frame bit has been consumed
//   host_active  high while the host strobes load within TIMEOUT_CYCLES
//
// Optional feature: define JOY_DB15_TX_TURBO_EN to add turbo_mask and the
// TURBO_LOADS parameter. A phase bit toggles every TURBO_LOADS load strobes;
// while it is 0, masked buttons are captured as released.
//
// SYNC_STAGES must be at least 2. The host must hold joy_clk high and low for
// at least SYNC_STAGES+2 clk cycles each.

module joy_db15_tx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLAYER_BITS    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 2400000
`ifdef JOY_DB15_TX_TURBO_EN
  ,
  parameter int unsigned TURBO_LOADS    = 4
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   joy_clk,
  input  logic                   joy_load,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
`ifdef JOY_DB15_TX_TURBO_EN
  input  logic [PLAYER_BITS-1:0] turbo_mask,
`endif
  output logic                   joy_data,
  output logic                   frame_done,
  output logic                   host_active
);

  localparam int unsigned FrameBits = 2 * PLAYER_BITS;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);
  localparam int unsigned ToW       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameBits);
  localparam logic [ToW-1:0]  ToLimit = ToW'(TIMEOUT_CYCLES);

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] load_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   load_prev_q;
  logic                   clk_prev_q;
  logic                   first_q;

  logic                   load_lvl;
  logic                   load_fall;
  logic                   clk_rise;

  // Shift chain and frame bookkeeping
  logic [FrameBits-1:0]   sr_q, sr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   done_q, done_d;

  // Activity monitor
  logic [ToW-1:0]         tcnt_q, tcnt_d;
  logic                   active_q, active_d;

  // Values captured during load (after optional turbo masking)
  logic [PLAYER_BITS-1:0] cap1;
  logic [PLAYER_BITS-1:0] cap2;

  always_comb begin
    load_lvl  = ~load_sync_q[SYNC_STAGES-1];
    // first_q masks spurious edges right after reset releases
    load_fall = ~load_sync_q[SYNC_STAGES-1] & load_prev_q & ~first_q;
    clk_rise  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q & ~first_q;
  end

`ifdef JOY_DB15_TX_TURBO_EN
  localparam int unsigned TlW = $clog2(TURBO_LOADS + 1);
  localparam logic [TlW-1:0] TlLimit = TlW'(TURBO_LOADS);

  logic [TlW-1:0]         lcnt_q, lcnt_d;
  logic                   phase_q, phase_d;
  logic [PLAYER_BITS-1:0] rel_mask;

  // The phase flips on the strobe that starts a new group of TURBO_LOADS
  // loads, and capture uses phase_d so that whole load sees the new phase.
  always_comb begin
    lcnt_d  = lcnt_q;
    phase_d = phase_q;
    if (load_fall) begin
      if (lcnt_q == TlLimit) begin
        lcnt_d  = TlW'(1);
        phase_d = ~phase_q;
      end else begin
        lcnt_d = lcnt_q + 1'b1;
      end
    end
    rel_mask = phase_d ? '0 : turbo_mask;
    cap1     = joystick1 & ~rel_mask;
    cap2     = joystick2 & ~rel_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    cap1 = joystick1;
    cap2 = joystick2;
  end
`endif

  // Load is level-sensitive and beats a coincident shift edge.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (load_lvl) begin
      sr_d  = ~{cap2, cap1};
      cnt_d = '0;
    end else if (clk_rise) begin
      sr_d = {1'b1, sr_q[FrameBits-1:1]};
      if (cnt_q != CntFull) begin
        cnt_d = cnt_q + 1'b1;
      end
      done_d = (cnt_q == CntLast);
    end
  end

  always_comb begin
    tcnt_d   = tcnt_q;
    active_d = active_q;
    if (load_fall) begin
      tcnt_d   = '0;
      active_d = 1'b1;
    end else begin
      if (tcnt_q != ToLimit) begin
        tcnt_d = tcnt_q + 1'b1;
      end
      if (tcnt_d == ToLimit) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_sync_q <= '1;
      clk_sync_q  <= '0;
      load_prev_q <= 1'b1;
      clk_prev_q  <= 1'b0;
      first_q     <= 1'b1;
      sr_q        <= '1;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      tcnt_q      <= '0;
      active_q    <= 1'b0;
    end else begin
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
      load_prev_q <= load_sync_q[SYNC_STAGES-1];
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      first_q     <= 1'b0;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      tcnt_q      <= tcnt_d;
      active_q    <= active_d;
    end
  end

  assign joy_data    = sr_q[0];
  assign frame_done  = done_q;
  assign host_active = active_q;

endmodule
